// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data-memory access controller:
// datapath widths, RV64I load/store funct3 encodings, the access FSM state
// type and a helper that turns an access size into a byte-enable mask.
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;

  // funct3 encodings; stores reuse the low four (SB/SH/SW/SD).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // funct3[1:0] is log2 of the access size in bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    unique case (size)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational load alignment: shifts the read doubleword right by the byte
// offset, then sign- or zero-extends the low byte/half/word per funct3.
// Ports:
//   rdata  in  XLEN  doubleword returned by data memory
//   offset in  3     byte offset of the access within the doubleword
//   funct3 in  3     load size/sign
//   data   out XLEN  extended load value
// ---------------------------------------------------------------------------
module load_extend #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);
  import mem_pkg::*;

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = rdata >> {offset, 3'b000};

  // NOTE: every output of a combinational block is assigned on all paths
  // (here via a full case with default) so no latch is inferred.
  always_comb begin
    unique case (funct3)
      F3_B:    data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
      F3_WU:   data = {{(XLEN-32){1'b0}},          w_shifted[31:0]};
      default: data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage data-memory access controller for the RV64I pipeline. Turns a
// load/store in the EX/MEM register into one request on a valid/ready
// channel, waits for the valid-only read response on loads, and stalls the
// pipeline until the access completes. Misaligned or illegal accesses raise
// mem_exc and issue nothing.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   memread_mem/memwrite_mem  load/store present in MEM (both = store)
//   funct3_mem                access size/sign
//   aluresult_mem             byte address
//   forwardBout_mem           store data, LSB-aligned
//   dmem_req_*                request channel (valid/ready, we, addr, wdata, wstrb)
//   dmem_rsp_valid/rdata      read response
//   mem_stall                 freeze PC/IF/ID/EX/MEM registers
//   loaddata_mem              extended load result (held until next load)
//   mem_exc                   misaligned/illegal access flag
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int XLEN   = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [2:0]        funct3_mem,
  input  logic [XLEN-1:0]   aluresult_mem,
  input  logic [XLEN-1:0]   forwardBout_mem,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [STRB_W-1:0] dmem_req_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rsp_rdata,
  output logic              mem_stall,
  output logic [XLEN-1:0]   loaddata_mem,
  output logic              mem_exc
);
  import mem_pkg::*;

  state_t            r_state;
  logic              r_req_valid;
  logic              r_req_we;
  logic [XLEN-1:0]   r_req_addr;
  logic [XLEN-1:0]   r_req_wdata;
  logic [STRB_W-1:0] r_req_wstrb;
  logic [2:0]        r_funct3;
  logic [2:0]        r_offset;
  logic [XLEN-1:0]   r_loaddata;

  logic              w_acc;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_start;
  logic [XLEN-1:0]   w_ext;

  assign w_acc = memread_mem | memwrite_mem;

  // A simultaneous read+write is a store, so store legality applies.
  assign w_illegal = memwrite_mem ? funct3_mem[2] : (funct3_mem == 3'b111);

  always_comb begin
    w_misaligned = 1'b0;
    unique case (funct3_mem[1:0])
      2'b01:   w_misaligned = aluresult_mem[0];
      2'b10:   w_misaligned = |aluresult_mem[1:0];
      2'b11:   w_misaligned = |aluresult_mem[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign mem_exc   = (r_state == IDLE) & w_acc & (w_illegal | w_misaligned);
  assign w_start   = (r_state == IDLE) & w_acc & ~mem_exc;
  // DONE deliberately drops the stall so EX/MEM advances by exactly one.
  assign mem_stall = w_start | (r_state == REQ) | (r_state == RSP);

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (dmem_rsp_rdata),
    .offset (r_offset),
    .funct3 (r_funct3),
    .data   (w_ext)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
      r_funct3    <= '0;
      r_offset    <= '0;
      r_loaddata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_req_valid <= 1'b1;
            r_req_we    <= memwrite_mem;
            r_req_addr  <= {aluresult_mem[XLEN-1:3], 3'b000};
            r_req_wdata <= forwardBout_mem << {aluresult_mem[2:0], 3'b000};
            r_req_wstrb <= size_mask(funct3_mem[1:0]) << aluresult_mem[2:0];
            r_funct3    <= funct3_mem;
            r_offset    <= aluresult_mem[2:0];
            r_state     <= REQ;
          end
        end
        REQ: begin
          // Request fields stay frozen until the handshake; stores are
          // posted and skip the response phase.
          if (dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_req_we ? DONE : RSP;
          end
        end
        RSP: begin
          if (dmem_rsp_valid) begin
            r_loaddata <= w_ext;
            r_state    <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req_valid = r_req_valid;
  assign dmem_req_we    = r_req_we;
  assign dmem_req_addr  = r_req_addr;
  assign dmem_req_wdata = r_req_wdata;
  assign dmem_req_wstrb = r_req_wstrb;
  assign loaddata_mem   = r_loaddata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench: acts as both the pipeline (EX/MEM inputs) and the data
// memory (ready delays, response delays, stray responses). Expected request
// fields, stall length, exception flag and load values come from a
// byte-arithmetic reference model of the access rules.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        memread_mem, memwrite_mem;
  logic [2:0]  funct3_mem;
  logic [63:0] aluresult_mem, forwardBout_mem;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        mem_stall;
  logic [63:0] loaddata_mem;
  logic        mem_exc;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] model_load = '0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .memread_mem     (memread_mem),
    .memwrite_mem    (memwrite_mem),
    .funct3_mem      (funct3_mem),
    .aluresult_mem   (aluresult_mem),
    .forwardBout_mem (forwardBout_mem),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wstrb  (dmem_req_wstrb),
    .dmem_rsp_valid  (dmem_rsp_valid),
    .dmem_rsp_rdata  (dmem_rsp_rdata),
    .mem_stall       (mem_stall),
    .loaddata_mem    (loaddata_mem),
    .mem_exc         (mem_exc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Load value from byte arithmetic: pick nbytes starting at byte off,
  // then replicate the top bit for signed sub-doubleword loads.
  function automatic logic [63:0] ref_extend(input logic [63:0] rdata,
                                             input logic [2:0] f3,
                                             input int off);
    int          nbytes;
    logic [63:0] mask;
    logic [63:0] v;
    nbytes = 1 << f3[1:0];
    mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    v      = (rdata >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    memread_mem = 1'b0; memwrite_mem = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    #1;
    check({tag, " idle stall"}, mem_stall, 0);
    check({tag, " idle valid"}, dmem_req_valid, 0);
  endtask

  // One complete access, pipeline and memory side together.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] data, input logic [63:0] rdata,
                        input int n_nrdy, input int n_wait);
    int          nbytes, exp_stall, stall_cnt, nrdy_cnt, wait_cnt, off;
    bit          is_store, exc, hs, rsp_sent, done_seen;
    logic [63:0] exp_addr, exp_wdata, exp_load;
    logic [7:0]  exp_strb;

    nbytes    = 1 << f3[1:0];
    off       = int'(addr[2:0]);
    is_store  = wr;
    exc       = is_store ? (f3 > 3'd3) : (f3 == 3'd7);
    exc       = exc || ((addr & 64'(nbytes - 1)) != 64'd0);
    exp_addr  = addr & ~64'd7;
    exp_wdata = data << (8 * off);
    exp_strb  = 8'(((1 << nbytes) - 1) << off);
    exp_stall = (is_store ? 2 : 3) + n_nrdy + (is_store ? 0 : n_wait);
    exp_load  = is_store ? model_load : ref_extend(rdata, f3, off);

    @(negedge clk);
    memread_mem = rd; memwrite_mem = wr; funct3_mem = f3;
    aluresult_mem = addr; forwardBout_mem = data;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    #1;
    if (exc) begin
      check({tag, " exc"}, mem_exc, 1);
      check({tag, " exc stall"}, mem_stall, 0);
      @(negedge clk);
      memread_mem = 1'b0; memwrite_mem = 1'b0;
      #1;
      check({tag, " exc no req"}, dmem_req_valid, 0);
      check({tag, " exc load kept"}, loaddata_mem, model_load);
      return;
    end
    check({tag, " no exc"}, mem_exc, 0);

    stall_cnt = 0; nrdy_cnt = 0; wait_cnt = 0;
    hs = 0; rsp_sent = 0; done_seen = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = {$urandom, $urandom};
      if (dmem_req_valid) begin
        check({tag, " req addr"},  dmem_req_addr, exp_addr);
        check({tag, " req we"},    dmem_req_we, is_store);
        check({tag, " req wstrb"}, dmem_req_wstrb, exp_strb);
        if (is_store) check({tag, " req wdata"}, dmem_req_wdata, exp_wdata);
        if (nrdy_cnt < n_nrdy) begin
          nrdy_cnt++;
          // A response while the request is pending must be ignored.
          dmem_rsp_valid = 1'($urandom_range(0, 1));
        end else begin
          dmem_req_ready = 1'b1;
          hs = 1;
        end
      end else if (hs && !is_store && !rsp_sent) begin
        if (wait_cnt < n_wait) wait_cnt++;
        else begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = rdata;
          rsp_sent = 1;
        end
      end
      #1;
      if (!mem_stall) begin
        done_seen = 1;
        break;
      end
      stall_cnt++;
    end
    if (!done_seen) check({tag, " timeout"}, 0, 1);
    check({tag, " stall cycles"}, 64'(stall_cnt), 64'(exp_stall));
    check({tag, " done valid"}, dmem_req_valid, 0);
    check({tag, " loaddata"}, loaddata_mem, exp_load);
    model_load = exp_load;
  endtask

  initial begin
    rstn = 1'b0;
    memread_mem = 1'b0; memwrite_mem = 1'b0; funct3_mem = '0;
    aluresult_mem = '0; forwardBout_mem = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset valid", dmem_req_valid, 0);
    check("reset we", dmem_req_we, 0);
    check("reset addr", dmem_req_addr, 0);
    check("reset wdata", dmem_req_wdata, 0);
    check("reset wstrb", dmem_req_wstrb, 0);
    check("reset loaddata", loaddata_mem, 0);
    check("reset stall", mem_stall, 0);
    rstn = 1'b1;

    // Directed cases.
    access("SD",  0, 1, 3'b011, 64'h1000, 64'h1122334455667788, 64'h0, 0, 0);
    access("SB",  0, 1, 3'b000, 64'h1003, 64'hAB, 64'h0, 0, 0);
    check("SB byte lane", 64'(dmem_req_wdata[31:24]), 64'hAB);
    access("LB",  1, 0, 3'b000, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 0, 2);
    check("LB value", loaddata_mem, 64'hFFFF_FFFF_FFFF_FF80);
    access("LBU", 1, 0, 3'b100, 64'h2005, 64'h0, 64'h0000_8000_0000_0000, 0, 0);
    check("LBU value", loaddata_mem, 64'h80);
    access("LW mis", 1, 0, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 0);
    access("SW wait", 0, 1, 3'b010, 64'h4004, 64'hDEADBEEF, 64'h0, 4, 0);
    access("LD ill7", 1, 0, 3'b111, 64'h5000, 64'h0, 64'h0, 0, 0);
    access("S ill4", 0, 1, 3'b100, 64'h5000, 64'h0, 64'h0, 0, 0);
    access("RW store", 1, 1, 3'b011, 64'h6008, 64'h0123456789ABCDEF, 64'hFFFF, 1, 0);
    access("LHU top", 1, 0, 3'b101, 64'h7006, 64'h0, 64'hFEDC_0000_0000_0000, 2, 1);
    idle_cycle("gap");

    // Reset while waiting for a response; the late response is ignored.
    @(negedge clk);
    memread_mem = 1'b1; memwrite_mem = 1'b0; funct3_mem = 3'b011; aluresult_mem = 64'h8000;
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    check("rst pre stall", mem_stall, 1);
    check("rst pre valid", dmem_req_valid, 0);
    rstn = 1'b0;
    memread_mem = 1'b0;
    #1;
    check("rst mid stall", mem_stall, 0);
    check("rst mid addr", dmem_req_addr, 0);
    check("rst mid strb", dmem_req_wstrb, 0);
    check("rst mid load", loaddata_mem, 0);
    @(negedge clk);
    rstn = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    check("rst late rsp stall", mem_stall, 0);
    check("rst late rsp valid", dmem_req_valid, 0);
    check("rst late rsp load", loaddata_mem, 0);
    model_load = '0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [63:0] addr;
      int          kind;
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      if ($urandom_range(0, 9) == 0) begin
        rd = 1'b1; wr = 1'b1;
      end
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(1 << f3[1:0]) - 64'd1);
      access("rnd", rd, wr, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) idle_cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
